bus_ram_target: RTL

- Memory-mapped responder (target) for the shared system bus driven by the CPU's memory-access unit.
- Decodes an address window, stalls a configurable number of wait states, then performs a byte-masked read or write on an internal synchronous word RAM.
- Signals completion on fc_bus and holds the response until the initiator releases rd_bus/wr_bus (full four-phase handshake).
- Instantiated once per RAM region; several instances share data_bus and fc_bus, so both are tri-stated when the instance is not responding.

---
 rtl/bus_ram_target_if.sv | 22 ++
 rtl/bus_ram_target.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bus_ram_target_if.sv
// Request side of the shared system bus: address, strobes and lane mask.
// data_bus and fc_bus are shared tri-state nets and stay as module ports.
interface bus_ram_target_if;
   logic [31:0] addr_bus;
   logic        rd_bus;
   logic        wr_bus;
   logic [3:0]  data_mask_bus;

   modport master (
      output addr_bus,
      output rd_bus,
      output wr_bus,
      output data_mask_bus
   );

   modport slave (
      input addr_bus,
      input rd_bus,
      input wr_bus,
      input data_mask_bus
   );
endinterface

// File: rtl/bus_ram_target.sv
// Bus RAM target: window decode, wait states, byte-masked access on a
// synchronous word RAM, four-phase fc handshake on shared tri-state nets.
module bus_ram_target #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned ADDR_BITS   = 10,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                clk,
   input  logic                rst,
   bus_ram_target_if.slave     bus,
   inout  wire  [31:0]         data_bus,
   output wire                 fc_bus,
   output logic                busy,
   output logic                err_misaligned
);
   localparam int unsigned DEPTH = 1 << ADDR_BITS;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 issued_q, issued_d;
   logic [ADDR_BITS-1:0] idx_q, idx_d;
   logic [1:0]           off_q, off_d;
   logic [3:0]           mask_q, mask_d;
   logic [31:0]          wdata_q, wdata_d;
   logic                 wr_q, wr_d;
   logic                 fc_q, fc_d;
   logic                 busy_q, busy_d;
   logic                 err_q, err_d;
   logic [31:0]          rdata_q, rdata_d;

   logic [31:0]          mem [DEPTH];
   logic [31:0]          ram_q;
   logic                 ram_re, ram_we;

   logic                 sel, req_ok, req_live, mis;
   logic [6:0]           lane_ext;
   logic [31:0]          wsh, rsh;

   assign sel      = bus.addr_bus[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2];
   assign req_ok   = sel && (bus.rd_bus ^ bus.wr_bus);
   assign req_live = wr_q ? bus.wr_bus : bus.rd_bus;
   assign lane_ext = {3'b000, mask_q} << off_q;
   assign mis      = |lane_ext[6:4];
   assign wsh      = wdata_q << {off_q, 3'b000};
   assign rsh      = ram_q >> {off_q, 3'b000};

   // RAM read is issued one cycle before RESP; the write lands on RESP entry
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      issued_d = issued_q;
      idx_d    = idx_q;
      off_d    = off_q;
      mask_d   = mask_q;
      wdata_d  = wdata_q;
      wr_d     = wr_q;
      fc_d     = fc_q;
      busy_d   = busy_q;
      err_d    = 1'b0;
      rdata_d  = rdata_q;
      ram_re   = 1'b0;
      ram_we   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_ok) begin
               state_d  = ACCESS;
               idx_d    = bus.addr_bus[ADDR_BITS+1:2];
               off_d    = bus.addr_bus[1:0];
               mask_d   = bus.data_mask_bus;
               wdata_d  = data_bus;
               wr_d     = bus.wr_bus;
               cnt_d    = 4'(WAIT_STATES);
               issued_d = 1'b0;
               busy_d   = 1'b1;
            end
         end
         ACCESS: begin
            if (!req_live) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (!issued_q) begin
               issued_d = 1'b1;
               ram_re   = 1'b1;
            end else begin
               ram_we  = wr_q && !mis;
               rdata_d = mis ? 32'h0 : rsh;
               err_d   = mis;
               fc_d    = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (!bus.rd_bus && !bus.wr_bus) begin
               state_d = IDLE;
               fc_d    = 1'b0;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         issued_q <= 1'b0;
         idx_q    <= '0;
         off_q    <= 2'd0;
         mask_q   <= 4'd0;
         wdata_q  <= 32'h0;
         wr_q     <= 1'b0;
         fc_q     <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= 32'h0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         issued_q <= issued_d;
         idx_q    <= idx_d;
         off_q    <= off_d;
         mask_q   <= mask_d;
         wdata_q  <= wdata_d;
         wr_q     <= wr_d;
         fc_q     <= fc_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   // RAM has no reset so contents survive rst
   always_ff @(posedge clk) begin
      if (ram_re) ram_q <= mem[idx_q];
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_ext[i]) mem[idx_q][8*i +: 8] <= wsh[8*i +: 8];
         end
      end
   end

   assign fc_bus         = fc_q ? 1'b1 : 1'bz;
   assign data_bus       = (fc_q && !wr_q) ? rdata_q : 32'hz;
   assign busy           = busy_q;
   assign err_misaligned = err_q;
endmodule
